multiword_subtractor: RTL
=========================

Name: multiword_subtractor

Overview:
- Multi-cycle wide subtractor. Computes D = A - B over BIT_LEN = NUM_WORDS*WORD_LEN bits, one WORD_LEN-bit limb per cycle, least significant limb first.
- The borrow is carried in a register between limbs.
- It is the subtract counterpart of the team's parallel-prefix adders. Each limb goes through one word-wide prefix-adder stage.
- Sits in the modular-arithmetic datapath wherever a full-width combinational subtract would break timing.

Parameters:
- WORD_LEN, 16: limb width; width of the internal prefix-adder stage.
- NUM_WORDS, 4: number of limbs; must be >= 1.
- BIT_LEN, WORD_LEN*NUM_WORDS: operand width; derived localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands on A/B are valid.
- in_ready  output  1  block can accept operands.
- A  input  BIT_LEN  minuend, unsigned.
- B  input  BIT_LEN  subtrahend, unsigned.
- out_valid  output  1  result on D/borrow is valid.
- out_ready  input  1  consumer accepts result.
- D  output  BIT_LEN  (A - B) mod 2^BIT_LEN.
- borrow  output  1  1 iff A < B (unsigned).

Behaviour:
- Interface:
  - One clock, clk. Reset rst is synchronous and active-high.
  - Reset takes effect at the clk edge where rst=1; it overrides all other inputs.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, D=0, borrow=0.
  - Internal limb index = 0, carry register = 1.
- FSM states: IDLE, RUN, DONE. Registered state only; in_ready = (state==IDLE) and out_valid = (state==DONE), both decoded directly from the state register.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at an edge: capture A and B into operand registers, set idx=0, carry=1, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN, at each edge:
  - Form limb sum {c, d} = A[idx] + ~B[idx] + carry. The word stage has WORD_LEN+1 output bits.
  - Write d into D[idx*WORD_LEN +: WORD_LEN]; carry <= c.
  - If idx==NUM_WORDS-1: go to DONE and set borrow <= ~c. Otherwise idx <= idx+1.
  - in_ready=0 throughout. in_valid is ignored and nothing is captured.
- DONE:
  - out_valid=1. D and borrow held stable until the handshake.
  - On out_ready=1: go to IDLE.
  - out_ready=0: stay in DONE indefinitely. D and borrow must not change.
- Latency:
  - Accept at edge E0; out_valid goes high after edge E0+NUM_WORDS.
  - Minimum initiation interval is NUM_WORDS+2 cycles (IDLE, NUM_WORDS x RUN, DONE). There is no same-cycle DONE-to-accept bypass.
- D contents:
  - D is overwritten limb by limb during RUN; limbs not yet written hold stale data.
  - D is only meaningful while out_valid=1.
- Width rules:
  - All arithmetic is unsigned modulo 2^BIT_LEN.
  - Carry-in of the subtraction = 1, i.e. two's complement.
  - Final borrow = NOT final carry.
- NUM_WORDS=1: RUN lasts exactly one cycle.
- Reset mid-operation (RUN or DONE): next cycle is IDLE with out_valid=0. The in-flight result is discarded and there is no partial output.
- Inputs A/B are sampled only at the accept edge; changes afterwards have no effect.

Decomposition:
- Shared package (adder package alongside the existing adder defines):
  - FSM state enum {IDLE, RUN, DONE}.
  - Function clog2-safe limb index width: max(1, $clog2(NUM_WORDS)).
- One sub-module: sub_word_stage.
  - Purely combinational, WORD_LEN wide.
  - Inputs a, b, cin; outputs d, cout.
  - Implemented as a WORD_LEN+1-bit addition of {a,1} + {~b,cin}, dropping bit 0, so cin folds into the carry-in-less parallel-prefix adder.
- The top module holds the FSM, operand registers, idx counter, carry register and D/borrow registers.

Test Plan:
(defaults WORD_LEN=16, NUM_WORDS=4)
1. Simple subtract: A=0x5, B=0x3, out_ready=1 -> D=0x0000_0000_0000_0002, borrow=0; out_valid rises 4 edges after accept and stays high for 1 cycle.
2. Full borrow ripple: A=0, B=1 -> D=0xFFFF_FFFF_FFFF_FFFF, borrow=1.
3. Cross-limb borrow: A=0x0001_0000_0000_0000, B=0x1 -> D=0x0000_FFFF_FFFF_FFFF, borrow=0. Equal operands 0xDEAD_BEEF_1234_5678 - same -> D=0, borrow=0.
4. Backpressure and busy inputs:
   - A=0x10, B=0x20 with out_ready=0 for 5 cycles -> out_valid=1, D=0xFFFF_FFFF_FFFF_FFF0, borrow=1, all stable.
   - in_ready=0 throughout, and toggling in_valid/A/B during RUN and DONE has no effect.
   - Raising out_ready -> IDLE the next cycle, in_ready=1.
5. Reset mid-op: assert rst one cycle during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, borrow=0. Then A=100, B=58 -> D=42, borrow=0.
6. Back-to-back random: 1000 random A/B pairs with random out_ready -> every result matches a (A-B) mod 2^64 / A<B reference model. No result lost or duplicated. Initiation interval >= 6 cycles.

Source files
------------

// File: rtl/multiword_subtractor_pkg.sv
// Shared definitions for the multi-cycle wide subtractor.
//   state_t   : FSM encoding (IDLE, RUN, DONE)
//   idx_width : width of the limb index register, never less than 1 bit
package multiword_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned num_words);
    return (num_words <= 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/multiword_subtractor_if.sv
// Operand/result handshake bundle for multiword_subtractor.
//   in_valid/in_ready   : operand handshake, A (minuend) and B (subtrahend)
//   out_valid/out_ready : result handshake, D = A - B and borrow = (A < B)
//   master : producer/consumer side, slave : subtractor side
interface multiword_subtractor_if #(
  parameter int unsigned WORD_LEN  = 16,
  parameter int unsigned NUM_WORDS = 4
);
  localparam int unsigned BIT_LEN = WORD_LEN * NUM_WORDS;

  logic               in_valid;
  logic               in_ready;
  logic [BIT_LEN-1:0] A;
  logic [BIT_LEN-1:0] B;
  logic               out_valid;
  logic               out_ready;
  logic [BIT_LEN-1:0] D;
  logic               borrow;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, D, borrow
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, D, borrow
  );
endinterface

// File: rtl/multiword_subtractor_sub_word_stage.sv
// One limb of the subtract: {cout, d} = a + ~b + cin.
//   a, b : WORD_LEN-bit limbs, cin : incoming carry (1 = no borrow)
//   d    : difference limb, cout : outgoing carry (0 = borrow out)
// The carry-in rides in bit 0 of a (WORD_LEN+1)-bit add of {a,1} + {~b,cin};
// bit 0 is discarded, so no separate carry-in port on the adder is needed.
module sub_word_stage #(
  parameter int unsigned WORD_LEN = 16
) (
  input  logic [WORD_LEN-1:0] a,
  input  logic [WORD_LEN-1:0] b,
  input  logic                cin,
  output logic [WORD_LEN-1:0] d,
  output logic                cout
);
  logic [WORD_LEN+1:0] w_sum;

  assign w_sum = {1'b0, a, 1'b1} + {1'b0, ~b, cin};
  assign d     = w_sum[WORD_LEN:1];
  assign cout  = w_sum[WORD_LEN+1];
endmodule

// File: rtl/multiword_subtractor.sv
// Multi-cycle wide subtractor: D = A - B over WORD_LEN*NUM_WORDS bits,
// one limb per cycle, least significant limb first, borrow carried in a
// register between limbs.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of multiword_subtractor_if (operands in, result out)
module multiword_subtractor
  import multiword_subtractor_pkg::*;
#(
  parameter int unsigned WORD_LEN  = 16,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  multiword_subtractor_if.slave  bus
);
  localparam int unsigned    BIT_LEN  = WORD_LEN * NUM_WORDS;
  localparam int unsigned    IW       = idx_width(NUM_WORDS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_WORDS - 1);

  state_t              r_state;
  logic [BIT_LEN-1:0]  r_a;
  logic [BIT_LEN-1:0]  r_b;
  logic [BIT_LEN-1:0]  r_d;
  logic [IW-1:0]       r_idx;
  logic                r_carry;
  logic                r_borrow;

  logic [WORD_LEN-1:0] w_a_limb;
  logic [WORD_LEN-1:0] w_b_limb;
  logic [WORD_LEN-1:0] w_d_limb;
  logic                w_cout;

  // Limb select by index compare keeps every part-select constant.
  always_comb begin
    w_a_limb = '0;
    w_b_limb = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_limb = r_a[i*WORD_LEN +: WORD_LEN];
        w_b_limb = r_b[i*WORD_LEN +: WORD_LEN];
      end
    end
  end

  sub_word_stage #(.WORD_LEN(WORD_LEN)) u_stage (
    .a    (w_a_limb),
    .b    (w_b_limb),
    .cin  (r_carry),
    .d    (w_d_limb),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b1;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_idx   <= '0;
            r_carry <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (r_idx == IW'(i)) r_d[i*WORD_LEN +: WORD_LEN] <= w_d_limb;
          end
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_borrow <= ~w_cout;
            r_state  <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.D         = r_d;
  assign bus.borrow    = r_borrow;
endmodule
